// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the load/store front end:
// funct3 size codes, FSM states, byte-enable patterns and request decode helpers.
package ram_access_ctrl_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD,
    ST_RESP
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Misaligned halfwords/words, unknown size codes and unsigned stores are rejected
  function automatic logic req_illegal(input logic store, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    case (funct3)
      MEM_B:   return 1'b0;
      MEM_H:   return addr_lo[0];
      MEM_W:   return addr_lo != 2'b00;
      MEM_BU:  return store;
      MEM_HU:  return store | addr_lo[0];
      default: return 1'b1;
    endcase
  endfunction

  // Byte lanes touched by a store of the given size at the given offset
  function automatic logic [3:0] store_byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      MEM_B:   return BE_B << addr_lo;
      MEM_H:   return addr_lo[1] ? BE_H_HI : BE_H_LO;
      MEM_W:   return BE_W;
      default: return BE_NONE;
    endcase
  endfunction

  // Store data stays low-aligned; bytes above the access size are zeroed
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      MEM_B:   return {24'b0, wdata[7:0]};
      MEM_H:   return {16'b0, wdata[15:0]};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Core request/response and RAM bus signals of the load/store front end.
// slave: the controller's view; master: the environment (core + RAM) view.
interface ram_access_ctrl_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_store_in;
  logic [2:0]  req_funct3_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic [31:0] ram_addr_out;
  logic [31:0] ram_wdata_out;
  logic        ram_read_en_out;
  logic        ram_write_en_out;
  logic [3:0]  ram_byte_en_out;
  logic        ram_valid_out;
  logic        ram_ready_in;
  logic        ram_rdata_valid_in;
  logic [31:0] ram_rdata_in;

  modport slave (
    input  req_valid_in, req_store_in, req_funct3_in, req_addr_in, req_wdata_in,
    input  resp_ready_in, ram_ready_in, ram_rdata_valid_in, ram_rdata_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
    output ram_addr_out, ram_wdata_out, ram_read_en_out, ram_write_en_out,
    output ram_byte_en_out, ram_valid_out
  );

  modport master (
    output req_valid_in, req_store_in, req_funct3_in, req_addr_in, req_wdata_in,
    output resp_ready_in, ram_ready_in, ram_rdata_valid_in, ram_rdata_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
    input  ram_addr_out, ram_wdata_out, ram_read_en_out, ram_write_en_out,
    input  ram_byte_en_out, ram_valid_out
  );
endinterface

// File: rtl/ram_access_ctrl_mem_lane_ext.sv
// Picks the addressed byte/halfword out of a RAM word and sign- or zero-extends it.
module mem_lane_ext
  import ram_access_ctrl_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  addr_lo_in,
  input  logic [2:0]  funct3_in,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension chosen by the size code
  always_comb begin
    byte_sel = word_in[{addr_lo_in, 3'b000} +: 8];
    half_sel = addr_lo_in[1] ? word_in[31:16] : word_in[15:0];
    case (funct3_in)
      MEM_B:   data_out = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data_out = {24'b0, byte_sel};
      MEM_H:   data_out = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data_out = {16'b0, half_sel};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Load/store front end: one core request at a time, alignment check,
// RAM valid/ready/rdata_valid handshake with read timeout, registered response.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic clk,
  input  logic rst,
  ram_access_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        ram_read_en_q, ram_read_en_d;
  logic        ram_write_en_q, ram_write_en_d;
  logic [3:0]  ram_byte_en_q, ram_byte_en_d;
  logic        ram_valid_q, ram_valid_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] lane_data;

  mem_lane_ext u_lane_ext (
    .word_in    (bus.ram_rdata_in),
    .addr_lo_in (addr_lo_q),
    .funct3_in  (funct3_q),
    .data_out   (lane_data)
  );

  assign bus.req_ready_out    = (state_q == ST_IDLE);
  assign bus.ram_addr_out     = ram_addr_q;
  assign bus.ram_wdata_out    = ram_wdata_q;
  assign bus.ram_read_en_out  = ram_read_en_q;
  assign bus.ram_write_en_out = ram_write_en_q;
  assign bus.ram_byte_en_out  = ram_byte_en_q;
  assign bus.ram_valid_out    = ram_valid_q;
  assign bus.resp_valid_out   = resp_valid_q;
  assign bus.resp_rdata_out   = resp_rdata_q;
  assign bus.resp_err_out     = resp_err_q;

  // Next-state and next-output decode; everything not touched holds its value
  always_comb begin
    state_d        = state_q;
    addr_lo_d      = addr_lo_q;
    funct3_d       = funct3_q;
    store_d        = store_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ram_read_en_d  = ram_read_en_q;
    ram_write_en_d = ram_write_en_q;
    ram_byte_en_d  = ram_byte_en_q;
    ram_valid_d    = ram_valid_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_in) begin
          addr_lo_d = bus.req_addr_in[1:0];
          funct3_d  = bus.req_funct3_in;
          store_d   = bus.req_store_in;
          if (req_illegal(bus.req_store_in, bus.req_funct3_in, bus.req_addr_in[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d        = ST_REQ;
            ram_valid_d    = 1'b1;
            ram_addr_d     = {bus.req_addr_in[31:2], 2'b00};
            ram_read_en_d  = ~bus.req_store_in;
            ram_write_en_d = bus.req_store_in;
            ram_byte_en_d  = bus.req_store_in ?
                             store_byte_en(bus.req_funct3_in, bus.req_addr_in[1:0]) : BE_NONE;
            ram_wdata_d    = bus.req_store_in ?
                             store_wdata(bus.req_funct3_in, bus.req_wdata_in) : '0;
          end
        end
      end
      ST_REQ: begin
        if (bus.ram_ready_in) begin
          ram_valid_d    = 1'b0;
          ram_read_en_d  = 1'b0;
          ram_write_en_d = 1'b0;
          ram_byte_en_d  = BE_NONE;
          ram_wdata_d    = '0;
          ram_addr_d     = '0;
          if (store_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
          end else begin
            state_d = ST_WAIT_RD;
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end
      end
      ST_WAIT_RD: begin
        if (bus.ram_rdata_valid_in) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = lane_data;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          phase_d = ~phase_q;
          if (phase_q) cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready_in) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single register stage for state and every output; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      addr_lo_q      <= '0;
      funct3_q       <= '0;
      store_q        <= 1'b0;
      cnt_q          <= '0;
      phase_q        <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_read_en_q  <= 1'b0;
      ram_write_en_q <= 1'b0;
      ram_byte_en_q  <= '0;
      ram_valid_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_lo_q      <= addr_lo_d;
      funct3_q       <= funct3_d;
      store_q        <= store_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_read_en_q  <= ram_read_en_d;
      ram_write_en_q <= ram_write_en_d;
      ram_byte_en_q  <= ram_byte_en_d;
      ram_valid_q    <= ram_valid_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: the bench plays both the core and a small word RAM.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_access_ctrl_if bus();

  ram_access_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem [16];

  logic [31:0] gotRdata;
  logic        gotErr;
  int          gotLat;
  bit          sawRamValid;
  bit          timedOut;
  int          unstable;
  int          holdBad;
  logic [31:0] snapAddr;
  logic [31:0] snapWdata;
  logic [3:0]  snapBe;
  logic        snapRd;
  logic        snapWr;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
  } bad_vec_t;

  ld_vec_t  loads [9];
  bad_vec_t bads  [5];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Writes low-aligned store data into the enabled lanes of the RAM word
  task automatic ramWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int sh;
    logic [31:0] shifted;
    sh = 0;
    for (int k = 3; k >= 0; k--) if (be[k]) sh = k;
    shifted = wdata << (8 * sh);
    for (int k = 0; k < 4; k++)
      if (be[k]) mem[addr[5:2]][8*k +: 8] = shifted[8*k +: 8];
  endtask

  // Issues one request from IDLE and runs core + RAM side cycle by cycle until the response is taken
  task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ramStall, input bit withhold,
                               input int respStall);
    bit hsPending = 0;
    bit gotResp   = 0;
    bit snapTaken = 0;
    bit done      = 0;
    int stallSeen = 0;
    int respSeen  = 0;
    gotRdata = 'x; gotErr = 1'bx; gotLat = -1;
    sawRamValid = 0; unstable = 0; holdBad = 0;
    bus.req_valid_in  = 1'b1;
    bus.req_store_in  = store;
    bus.req_funct3_in = f3;
    bus.req_addr_in   = addr;
    bus.req_wdata_in  = wdata;
    bus.ram_ready_in  = 1'b0;
    bus.resp_ready_in = 1'b0;
    bus.ram_rdata_valid_in = 1'b0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      stepCycle();
      bus.req_valid_in = 1'b0;
      bus.ram_rdata_valid_in = 1'b0;
      if (bus.resp_ready_in) begin
        if (bus.resp_valid_out !== 1'b0) holdBad++;
        if (bus.req_ready_out !== 1'b1) holdBad++;
        bus.resp_ready_in = 1'b0;
        done = 1;
      end else begin
        if (hsPending) begin
          hsPending = 0;
          if (snapWr) ramWrite(snapAddr, snapWdata, snapBe);
          else if (!withhold) begin
            bus.ram_rdata_valid_in = 1'b1;
            bus.ram_rdata_in = mem[snapAddr[5:2]];
          end
        end
        bus.ram_ready_in = 1'b0;
        if (bus.ram_valid_out) begin
          sawRamValid = 1;
          if (!snapTaken) begin
            snapTaken = 1;
            snapAddr  = bus.ram_addr_out;
            snapWdata = bus.ram_wdata_out;
            snapBe    = bus.ram_byte_en_out;
            snapRd    = bus.ram_read_en_out;
            snapWr    = bus.ram_write_en_out;
          end else if (bus.ram_addr_out !== snapAddr || bus.ram_wdata_out !== snapWdata ||
                       bus.ram_byte_en_out !== snapBe || bus.ram_read_en_out !== snapRd ||
                       bus.ram_write_en_out !== snapWr) begin
            unstable++;
          end
          if (stallSeen < ramStall) stallSeen++;
          else begin
            bus.ram_ready_in = 1'b1;
            hsPending = 1;
          end
        end
        if (bus.resp_valid_out) begin
          if (!gotResp) begin
            gotResp  = 1;
            gotRdata = bus.resp_rdata_out;
            gotErr   = bus.resp_err_out;
            gotLat   = cyc;
          end else if (bus.resp_rdata_out !== gotRdata || bus.resp_err_out !== gotErr) begin
            holdBad++;
          end
          if (bus.req_ready_out !== 1'b0) holdBad++;
          if (respSeen >= respStall) bus.resp_ready_in = 1'b1;
          respSeen++;
        end
      end
    end
    timedOut = !done;
    bus.ram_ready_in = 1'b0;
    bus.ram_rdata_valid_in = 1'b0;
    bus.resp_ready_in = 1'b0;
  endtask

  initial begin
    int respCount;
    bus.req_valid_in = 1'b0;
    bus.req_store_in = 1'b0;
    bus.req_funct3_in = '0;
    bus.req_addr_in = '0;
    bus.req_wdata_in = '0;
    bus.resp_ready_in = 1'b0;
    bus.ram_ready_in = 1'b0;
    bus.ram_rdata_valid_in = 1'b0;
    bus.ram_rdata_in = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'h8081_7F01;
    mem[2] = 32'h1122_3344;

    loads = '{
      '{32'h5, MEM_B,  32'h0000_007F},
      '{32'h7, MEM_B,  32'hFFFF_FF80},
      '{32'h7, MEM_BU, 32'h0000_0080},
      '{32'h6, MEM_B,  32'hFFFF_FF81},
      '{32'h6, MEM_H,  32'hFFFF_8081},
      '{32'h6, MEM_HU, 32'h0000_8081},
      '{32'h4, MEM_H,  32'h0000_7F01},
      '{32'h4, MEM_W,  32'h8081_7F01},
      '{32'h4, MEM_BU, 32'h0000_0001}
    };
    bads = '{
      '{1'b0, MEM_W,  32'h2},
      '{1'b1, MEM_H,  32'h3},
      '{1'b0, 3'b011, 32'h0},
      '{1'b1, MEM_BU, 32'h0},
      '{1'b0, 3'b110, 32'h8}
    };

    // reset state
    repeat (3) stepCycle();
    checkOutput("rst_req_ready", 32'(bus.req_ready_out), 32'd1);
    checkOutput("rst_ram_valid", 32'(bus.ram_valid_out), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid_out), 32'd0);
    checkOutput("rst_resp_err", 32'(bus.resp_err_out), 32'd0);
    checkOutput("rst_resp_rdata", bus.resp_rdata_out, 32'd0);
    checkOutput("rst_byte_en", 32'(bus.ram_byte_en_out), 32'd0);
    checkOutput("rst_ram_addr", bus.ram_addr_out, 32'd0);
    checkOutput("rst_rw_en", 32'({bus.ram_read_en_out, bus.ram_write_en_out}), 32'd0);
    rst = 1'b1;
    stepCycle();

    // loads: lane select, extension, latency
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, loads[i].f3, loads[i].addr, 32'h0, 0, 1'b0, 0);
      checkOutput($sformatf("load%0d_done", i), 32'(timedOut), 32'd0);
      checkOutput($sformatf("load%0d_rdata", i), gotRdata, loads[i].exp);
      checkOutput($sformatf("load%0d_err", i), 32'(gotErr), 32'd0);
      checkOutput($sformatf("load%0d_lat", i), 32'(gotLat), 32'd3);
    end
    checkOutput("load_read_en", 32'({snapRd, snapWr}), 32'b10);
    checkOutput("load_ram_addr", snapAddr, 32'h4);
    checkOutput("load_byte_en", 32'(snapBe), 32'd0);

    // byte store into the top lane, then read the word back
    applyStimulus(1'b1, MEM_B, 32'hB, 32'h1234_56AA, 0, 1'b0, 0);
    checkOutput("sb_done", 32'(timedOut), 32'd0);
    checkOutput("sb_byte_en", 32'(snapBe), 32'b1000);
    checkOutput("sb_wdata", snapWdata, 32'h0000_00AA);
    checkOutput("sb_addr", snapAddr, 32'h8);
    checkOutput("sb_write_en", 32'({snapRd, snapWr}), 32'b01);
    checkOutput("sb_lat", 32'(gotLat), 32'd2);
    checkOutput("sb_resp", {gotRdata[30:0], gotErr}, 32'd0);
    applyStimulus(1'b0, MEM_W, 32'h8, 32'h0, 0, 1'b0, 0);
    checkOutput("sb_readback", gotRdata, 32'hAA22_3344);

    // halfword store into the upper half
    applyStimulus(1'b1, MEM_H, 32'hE, 32'hCAFE_BEEF, 0, 1'b0, 0);
    checkOutput("sh_byte_en", 32'(snapBe), 32'b1100);
    checkOutput("sh_wdata", snapWdata, 32'h0000_BEEF);
    applyStimulus(1'b0, MEM_W, 32'hC, 32'h0, 0, 1'b0, 0);
    checkOutput("sh_readback", gotRdata, 32'hBEEF_0000);

    // illegal requests: error response without touching the RAM
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bads[i].store, bads[i].f3, bads[i].addr, 32'hFFFF_FFFF, 0, 1'b0, 0);
      checkOutput($sformatf("bad%0d_done", i), 32'(timedOut), 32'd0);
      checkOutput($sformatf("bad%0d_err", i), 32'(gotErr), 32'd1);
      checkOutput($sformatf("bad%0d_rdata", i), gotRdata, 32'd0);
      checkOutput($sformatf("bad%0d_ram_valid", i), 32'(sawRamValid), 32'd0);
      checkOutput($sformatf("bad%0d_lat", i), 32'(gotLat), 32'd1);
    end

    // RAM busy for 5 cycles: request fields must hold
    applyStimulus(1'b0, MEM_W, 32'h4, 32'h0, 5, 1'b0, 0);
    checkOutput("stall_unstable", 32'(unstable), 32'd0);
    checkOutput("stall_rdata", gotRdata, 32'h8081_7F01);
    checkOutput("stall_lat", 32'(gotLat), 32'd8);

    // read data never arrives: timeout error
    applyStimulus(1'b0, MEM_W, 32'h4, 32'h0, 0, 1'b1, 0);
    checkOutput("to_done", 32'(timedOut), 32'd0);
    checkOutput("to_err", 32'(gotErr), 32'd1);
    checkOutput("to_rdata", gotRdata, 32'd0);
    checkOutput("to_lat", 32'(gotLat), 32'd35);

    // core not ready for 3 cycles: response held, no new request accepted
    applyStimulus(1'b0, MEM_H, 32'h6, 32'h0, 0, 1'b0, 3);
    checkOutput("hold_bad", 32'(holdBad), 32'd0);
    checkOutput("hold_rdata", gotRdata, 32'hFFFF_8081);

    // reset while waiting for read data: back to IDLE with no response
    bus.req_valid_in  = 1'b1;
    bus.req_store_in  = 1'b0;
    bus.req_funct3_in = MEM_W;
    bus.req_addr_in   = 32'h4;
    stepCycle();
    bus.req_valid_in = 1'b0;
    bus.ram_ready_in = 1'b1;
    stepCycle();
    bus.ram_ready_in = 1'b0;
    stepCycle();
    rst = 1'b0;
    stepCycle();
    rst = 1'b1;
    checkOutput("midrst_ram_valid", 32'(bus.ram_valid_out), 32'd0);
    checkOutput("midrst_resp_valid", 32'(bus.resp_valid_out), 32'd0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready_out), 32'd1);
    respCount = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (bus.resp_valid_out) respCount++;
    end
    checkOutput("midrst_no_resp", 32'(respCount), 32'd0);

    applyStimulus(1'b0, MEM_BU, 32'h6, 32'h0, 0, 1'b0, 0);
    checkOutput("recover_rdata", gotRdata, 32'h0000_0081);
    checkOutput("recover_lat", 32'(gotLat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
